rat_io_hub: RTL
===============

Name: rat_io_hub

Overview:
- Parametrised port-mapped I/O hub between RAT_MCU (IN_PORT/OUT_PORT/PORT_ID/IO_STRB/INTR) and board peripherals.
- Generalises the single-switch/single-LED wrapper logic to N_IN input and N_OUT output channels of width W.
- Adds three features:
  - input synchronisation;
  - per-channel change-detect interrupts with mask and write-1-to-clear acknowledge;
  - output-register readback.

Parameters:
- N_IN, 4, number of input channels (1..W).
- N_OUT, 4, number of output registers (1..16).
- W, 8, data width; MCU port width, fixed 8 in current MCU.
- IN_BASE, 8'h20, PORT_ID of input channel 0; channel k at IN_BASE+k.
- OUT_BASE, 8'h40, PORT_ID of output register 0; register k at OUT_BASE+k.
- STATUS_ID, 8'hF0, read-only pending-interrupt flags.
- MASK_ID, 8'hF1, read/write interrupt mask.
- ACK_ID, 8'hF2, write-1-to-clear pending flags.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PORT_ID  in  8  MCU port address.
- OUT_PORT  in  W  MCU write data.
- IO_STRB  in  1  MCU write strobe, level-qualified.
- IN_PORT  out  W  read data to MCU, combinational from PORT_ID.
- INTR  out  1  interrupt request to MCU, registered level.
- IN_DATA  in  N_IN*W  asynchronous peripheral inputs; channel k at bits [k*W +: W].
- OUT_DATA  out  N_OUT*W  output registers; register k at bits [k*W +: W].

Behaviour:
- Reset (RESET_N low, asynchronous): clears all output registers, sync flops, prev-value flops, pending, mask, INTR, and the warm-up counter.
- Input sync:
  - Each IN_DATA channel passes through a 2-flop synchroniser; sync value visible 2 cycles after input change.
- Read mux (combinational on PORT_ID), in priority order:
  1. IN_BASE..IN_BASE+N_IN-1: synchronised channel.
  2. OUT_BASE..+N_OUT-1: current output register.
  3. STATUS_ID: pending zero-extended.
  4. MASK_ID: mask zero-extended.
  5. Anything else: 0.
- Writes, on a rising edge with IO_STRB=1:
  - OUT range: register <= OUT_PORT.
  - MASK_ID: mask <= OUT_PORT[N_IN-1:0].
  - ACK_ID: pending <= pending & ~OUT_PORT[N_IN-1:0].
  - Any other ID is ignored.
  - A strobe held multiple cycles rewrites the same value (idempotent).
- Change detect:
  - event[k] = (sync[k] != prev[k]) && warm.
  - prev <= sync every cycle.
  - On event, pending[k] is set in the same edge.
- Warm-up:
  - 2-bit counter increments after reset until it reaches 3; warm = (count==3).
  - This suppresses spurious events while the sync pipeline fills.
- Event on a masked channel: pending is still set; only INTR is gated by mask.
- Simultaneous set and ACK on the same channel in the same cycle: set wins, pending stays 1.
- Simultaneous MASK write and event: the new mask applies from the next cycle's INTR computation.
- INTR <= |(pending & mask), registered: one cycle after the pending/mask update.
  - Remains high until all masked pending bits are cleared or masked off.
- Elaboration-time assertions:
  - no overlap between the IN range, OUT range, and the three control IDs;
  - N_IN <= W.
- Reset mid-operation: all state clears immediately; warm-up restarts on RESET_N release.

Decomposition:
- Shared package rat_io_pkg:
  - default port ID localparams: IN_BASE, OUT_BASE, STATUS_ID, MASK_ID, ACK_ID;
  - a function in_range(id, base, n) used by both decoders.
- Sub-module rat_io_sync_edge, instantiated per input channel in a generate loop:
  - inputs: CLK, RESET_N, async W-bit input, warm;
  - outputs: sync value and 1-bit change event.
- Pending/mask/INTR logic and address decode remain in rat_io_hub.

Test Plan:
- Reset then write: hold RESET_N=0 5 cycles, release; PORT_ID=8'h41, OUT_PORT=8'hA5, IO_STRB=1 one cycle -> OUT_DATA[15:8]=8'hA5, all other output bytes 0. PORT_ID=8'h41 read -> IN_PORT=8'hA5.
- Input read latency: IN_DATA channel 2 set to 8'h3C at cycle t -> PORT_ID=8'h22 reads 0 at t+1 and 8'h3C from t+2.
- Interrupt path:
  - Write MASK_ID=8'h04; toggle channel 2 -> STATUS read 8'h04, INTR=1 one cycle after pending.
  - Write ACK_ID=8'h04 -> pending 0, INTR=0 next cycle.
- Masked channel plus set-wins:
  - Toggle channel 0 with mask 8'h04 -> STATUS=8'h01, INTR stays 0.
  - ACK channel 2 in the same cycle as a channel-2 event -> bit 2 stays 1.
- Boundaries and warm-up:
  - Assert reset while INTR=1 and outputs are nonzero -> everything is 0 immediately and asynchronously.
  - Non-zero IN_DATA held through reset release -> no pending bits.
  - Write to PORT_ID=8'h44 (outside OUT range with N_OUT=4) -> no register changes; read returns 0.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared constants and address-decode helper for the RAT_MCU port-mapped I/O hub.
package rat_io_pkg;

    localparam logic [7:0] IN_BASE_DEF   = 8'h20;
    localparam logic [7:0] OUT_BASE_DEF  = 8'h40;
    localparam logic [7:0] STATUS_ID_DEF = 8'hF0;
    localparam logic [7:0] MASK_ID_DEF   = 8'hF1;
    localparam logic [7:0] ACK_ID_DEF    = 8'hF2;

    // True when id falls in [base, base+n); done in int so base+n cannot wrap.
    function automatic logic in_range(input logic [7:0] id, input logic [7:0] base, input int n);
        return (int'(id) >= int'(base)) && (int'(id) < int'(base) + n);
    endfunction

endpackage

// File: rtl/rat_io_sync_edge.sv
// One input channel: 2-flop synchroniser plus previous-value register for change detection.
module rat_io_sync_edge #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [W-1:0] async_i,
    input  logic         warm_i,
    output logic [W-1:0] sync_o,
    output logic         chg_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    // Gated until the synchroniser has filled so reset-time input values do not look like edges.
    assign chg_o  = warm_i && (sync_q != prev_q);

endmodule

// File: rtl/rat_io_hub.sv
// Port-mapped I/O hub for RAT_MCU: synchronised inputs, output registers with readback,
// and per-channel change-detect interrupts with mask and write-1-to-clear acknowledge.
module rat_io_hub
    import rat_io_pkg::*;
#(
    parameter int         N_IN      = 4,
    parameter int         N_OUT     = 4,
    parameter int         W         = 8,
    parameter logic [7:0] IN_BASE   = IN_BASE_DEF,
    parameter logic [7:0] OUT_BASE  = OUT_BASE_DEF,
    parameter logic [7:0] STATUS_ID = STATUS_ID_DEF,
    parameter logic [7:0] MASK_ID   = MASK_ID_DEF,
    parameter logic [7:0] ACK_ID    = ACK_ID_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [7:0]         PORT_ID,
    input  logic [W-1:0]       OUT_PORT,
    input  logic               IO_STRB,
    output logic [W-1:0]       IN_PORT,
    output logic               INTR,
    input  logic [N_IN*W-1:0]  IN_DATA,
    output logic [N_OUT*W-1:0] OUT_DATA
);

    localparam bit RANGES_OVERLAP =
        (int'(IN_BASE) < int'(OUT_BASE) + N_OUT) && (int'(OUT_BASE) < int'(IN_BASE) + N_IN);
    localparam bit CTRL_IN_RANGE =
        in_range(STATUS_ID, IN_BASE, N_IN) || in_range(STATUS_ID, OUT_BASE, N_OUT) ||
        in_range(MASK_ID,   IN_BASE, N_IN) || in_range(MASK_ID,   OUT_BASE, N_OUT) ||
        in_range(ACK_ID,    IN_BASE, N_IN) || in_range(ACK_ID,    OUT_BASE, N_OUT);
    localparam bit CTRL_DUP =
        (STATUS_ID == MASK_ID) || (STATUS_ID == ACK_ID) || (MASK_ID == ACK_ID);

    if (N_IN < 1 || N_IN > W) begin : g_bad_n_in
        $error("rat_io_hub: N_IN must be in 1..W");
    end
    if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
        $error("rat_io_hub: N_OUT must be in 1..16");
    end
    if (RANGES_OVERLAP || CTRL_IN_RANGE || CTRL_DUP) begin : g_bad_map
        $error("rat_io_hub: port ID map has overlapping entries");
    end

    logic [1:0]      warm_cnt_q, warm_cnt_d;
    logic            warm;
    logic [W-1:0]    sync_ch [N_IN];
    logic [N_IN-1:0] chg;
    logic [W-1:0]    out_q [N_OUT];
    logic [W-1:0]    out_d [N_OUT];
    logic [N_IN-1:0] mask_q, mask_d;
    logic [N_IN-1:0] pend_q, pend_d;
    logic            intr_q, intr_d;
    logic [N_IN-1:0] ack_bits;
    logic            wr_out, wr_mask, wr_ack;
    logic            rd_in, rd_out;
    logic [W-1:0]    rd_data;

    assign warm       = (warm_cnt_q == 2'd3);
    assign warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + 2'd1;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        rat_io_sync_edge #(.W(W)) u_sync (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .async_i (IN_DATA[k*W +: W]),
            .warm_i  (warm),
            .sync_o  (sync_ch[k]),
            .chg_o   (chg[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign OUT_DATA[k*W +: W] = out_q[k];
    end

    assign rd_in    = in_range(PORT_ID, IN_BASE, N_IN);
    assign rd_out   = in_range(PORT_ID, OUT_BASE, N_OUT);
    assign wr_out   = IO_STRB && rd_out;
    assign wr_mask  = IO_STRB && (PORT_ID == MASK_ID);
    assign wr_ack   = IO_STRB && (PORT_ID == ACK_ID);
    assign ack_bits = wr_ack ? OUT_PORT[N_IN-1:0] : '0;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = out_q[k];
            if (wr_out && (PORT_ID == OUT_BASE + 8'(k))) out_d[k] = OUT_PORT;
        end
        mask_d = wr_mask ? OUT_PORT[N_IN-1:0] : mask_q;
        // A new event on the same edge as its acknowledge keeps the flag set.
        pend_d = (pend_q & ~ack_bits) | chg;
        intr_d = |(pend_q & mask_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            warm_cnt_q <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            intr_q     <= 1'b0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            intr_q     <= intr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in) begin
            for (int k = 0; k < N_IN; k++)
                if (PORT_ID == IN_BASE + 8'(k)) rd_data = sync_ch[k];
        end else if (rd_out) begin
            for (int k = 0; k < N_OUT; k++)
                if (PORT_ID == OUT_BASE + 8'(k)) rd_data = out_q[k];
        end else if (PORT_ID == STATUS_ID) begin
            rd_data = W'(pend_q);
        end else if (PORT_ID == MASK_ID) begin
            rd_data = W'(mask_q);
        end
    end

    assign IN_PORT = rd_data;
    assign INTR    = intr_q;

endmodule
